// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external adder among N_REQ requesters
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_result,
  output logic [WIDTH-1:0]       result,
  output logic                   result_valid,
  output logic [ID_W-1:0]        result_id,
  output logic                   busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, rid_q, rid_d, win;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic vld_q, vld_d, take, found;
  // Search upward from ptr; index arithmetic wraps naturally since N_REQ is 2**ID_W
  always_comb begin
    win = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[ptr_q + ID_W'(k)]) begin
        win = ptr_q + ID_W'(k);
        found = 1'b1;
      end
    end
  end
  assign take = state_q == IDLE && |req;
  assign busy = state_q == BUSY;
  assign gnt = (!rst && take) ? N_REQ'(1) << win : '0;
  always_comb begin
    state_d = take ? BUSY : busy ? IDLE : state_q;
    opa_d = take ? a_in[win*WIDTH +: WIDTH] : opa_q;
    opb_d = take ? b_in[win*WIDTH +: WIDTH] : opb_q;
    id_d = take ? win : id_q;
    res_d = busy ? add_result : res_q;
    rid_d = busy ? id_q : rid_q;
    ptr_d = busy ? id_q + ID_W'(1) : ptr_q;
    vld_d = busy;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      rid_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      rid_q <= rid_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end
  assign add_a = opa_q;
  assign add_b = opb_q;
  assign result = res_q;
  assign result_id = rid_q;
  assign result_valid = vld_q;
endmodule
